control_unit: RTL and testbench

- Top-level sequencing FSM for the neural-network accelerator.
- Accepts a start request and image word, then sequences: weight fetch -> forward pass -> (backprop when training | result draw) -> idle.
- Drives one-hot request strobes to the weight store, FP engine, BP engine and display/draw unit.
- Forwards the captured image word to the datapath.

---
 rtl/control_unit_pkg.sv | 39 +++
 rtl/control_unit_if.sv | 27 ++
 rtl/control_unit.sv | 83 ++++++++
 tb/tb_control_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared types for the accelerator sequencer: run-state encoding, strobe bundle
// and the default datapath width reused by the FP/BP/draw blocks.
package control_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WEIGHTS = 3'd1,
    ST_FP      = 3'd2,
    ST_BP      = 3'd3,
    ST_DRAW    = 3'd4
  } state_e;

  typedef struct packed {
    logic get_all_weights;
    logic do_fp;
    logic do_bp;
    logic draw;
  } strobe_t;

  localparam strobe_t STROBES_OFF = '{1'b0, 1'b0, 1'b0, 1'b0};

  // Any encoding outside the five legal states decodes as IDLE (all strobes low).
  function automatic strobe_t state_strobes(input state_e s);
    strobe_t r;
    r = STROBES_OFF;
    case (s)
      ST_IDLE:    r = STROBES_OFF;
      ST_WEIGHTS: r.get_all_weights = 1'b1;
      ST_FP:      r.do_fp = 1'b1;
      ST_BP:      r.do_bp = 1'b1;
      ST_DRAW:    r.draw = 1'b1;
      default:    r = STROBES_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Handshake bundle between the sequencer (master) and the engines/host (slave).
interface control_unit_if #(
  parameter int WIDTH = 32
);
  logic             train;
  logic             start;
  logic             weights_ack;
  logic             bp_done;
  logic             fp_done;
  logic             drawn;
  logic [WIDTH-1:0] image_in;
  logic             get_all_weights;
  logic             do_fp;
  logic             do_bp;
  logic             draw;
  logic [WIDTH-1:0] image_out;

  modport master (
    input  train, start, weights_ack, bp_done, fp_done, drawn, image_in,
    output get_all_weights, do_fp, do_bp, draw, image_out
  );

  modport slave (
    output train, start, weights_ack, bp_done, fp_done, drawn, image_in,
    input  get_all_weights, do_fp, do_bp, draw, image_out
  );
endinterface

// File: rtl/control_unit.sv
// Top-level run sequencer: IDLE -> WEIGHTS -> FP -> (BP | DRAW) -> IDLE.
// Strobes are flopped from the next state so they change exactly with the state.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master cu
);

  state_e           cs_q;
  state_e           cs_d;
  strobe_t          strb_q;
  strobe_t          strb_d;
  logic [WIDTH-1:0] image_q;
  logic [WIDTH-1:0] image_d;

  // Next-state logic; each state only looks at its own done/ack input.
  always_comb begin
    cs_d = cs_q;
    case (cs_q)
      ST_IDLE: begin
        if (cu.start) cs_d = ST_WEIGHTS;
        else          cs_d = ST_IDLE;
      end
      ST_WEIGHTS: begin
        if (cu.weights_ack) cs_d = ST_FP;
        else                cs_d = ST_WEIGHTS;
      end
      ST_FP: begin
        if (cu.fp_done) begin
          if (cu.train) cs_d = ST_BP;
          else          cs_d = ST_DRAW;
        end else begin
          cs_d = ST_FP;
        end
      end
      ST_BP: begin
        if (cu.bp_done) cs_d = ST_IDLE;
        else            cs_d = ST_BP;
      end
      ST_DRAW: begin
        if (cu.drawn) cs_d = ST_IDLE;
        else          cs_d = ST_DRAW;
      end
      default: cs_d = ST_IDLE;
    endcase
  end

  // Image word is captured only on the IDLE->WEIGHTS edge and held for the run.
  always_comb begin
    image_d = image_q;
    if ((cs_q == ST_IDLE) && cu.start) image_d = cu.image_in;
    else                               image_d = image_q;
  end

  // Strobes for the state being entered, so they are registered yet Moore-aligned.
  always_comb begin
    strb_d = state_strobes(cs_d);
  end

  // State, strobe and image registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_q    <= ST_IDLE;
      strb_q  <= STROBES_OFF;
      image_q <= {WIDTH{1'b0}};
    end else begin
      cs_q    <= cs_d;
      strb_q  <= strb_d;
      image_q <= image_d;
    end
  end

  assign cu.get_all_weights = strb_q.get_all_weights;
  assign cu.do_fp           = strb_q.do_fp;
  assign cu.do_bp           = strb_q.do_bp;
  assign cu.draw            = strb_q.draw;
  assign cu.image_out       = image_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: directed scenarios plus random stimulus against a run-phase model.
module tb_control_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // Reference model: phase 0 = idle, 1 = weights, 2 = fp, 3 = bp, 4 = draw.
  int          m_phase;
  logic [W-1:0] m_image;

  control_unit_if #(.WIDTH(W)) cu ();

  control_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .cu  (cu.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] expected_strobes(input int phase);
    logic [3:0] one;
    one = 4'b1000;
    if (phase >= 1 && phase <= 4) return one >> (phase - 1);
    else                          return 4'b0000;
  endfunction

  // Advance one clock: update the model from the inputs seen at the edge, then check.
  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      m_phase = 0;
      m_image = '0;
    end else if (m_phase == 0) begin
      if (cu.start) begin
        m_phase = 1;
        m_image = cu.image_in;
      end
    end else if (m_phase == 1) begin
      if (cu.weights_ack) m_phase = 2;
    end else if (m_phase == 2) begin
      if (cu.fp_done) m_phase = cu.train ? 3 : 4;
    end else if (m_phase == 3) begin
      if (cu.bp_done) m_phase = 0;
    end else if (m_phase == 4) begin
      if (cu.drawn) m_phase = 0;
    end
    @(negedge clk);
    check_eq("strobes", {60'd0, cu.get_all_weights, cu.do_fp, cu.do_bp, cu.draw},
             {60'd0, expected_strobes(m_phase)});
    check_eq("image_out", {32'd0, cu.image_out}, {32'd0, m_image});
  endtask

  task automatic clear_inputs();
    cu.start = 1'b0; cu.train = 1'b0; cu.weights_ack = 1'b0;
    cu.fp_done = 1'b0; cu.bp_done = 1'b0; cu.drawn = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_phase  = 0;
    m_image  = '0;
    rst = 1'b0;
    clear_inputs();
    cu.image_in = 32'hCAFE0001;
    cu.start = 1'b1;

    // Reset held two cycles with start asserted.
    cycle();
    cycle();
    check_eq("reset_image", {32'd0, cu.image_out}, 64'd0);

    // Inference run with stall/ignore window in WEIGHTS.
    rst = 1'b1;
    cu.image_in = 32'hDEADBEEF;
    cycle();
    check_eq("inf_weights", {63'd0, cu.get_all_weights}, 64'd1);
    check_eq("inf_capture", {32'd0, cu.image_out}, {32'd0, 32'hDEADBEEF});
    cu.start = 1'b0;
    cu.image_in = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      cu.fp_done = i[0]; cu.drawn = ~i[0]; cu.bp_done = i[1];
      cycle();
    end
    check_eq("stall_hold", {63'd0, cu.get_all_weights}, 64'd1);
    check_eq("stall_image", {32'd0, cu.image_out}, {32'd0, 32'hDEADBEEF});
    clear_inputs();
    cu.weights_ack = 1'b1;
    cycle();
    check_eq("inf_fp", {63'd0, cu.do_fp}, 64'd1);
    cu.weights_ack = 1'b0; cu.fp_done = 1'b1; cu.train = 1'b0;
    cycle();
    check_eq("inf_draw", {62'd0, cu.draw, cu.do_bp}, 64'd2);
    cu.fp_done = 1'b0; cu.drawn = 1'b1;
    cycle();
    check_eq("inf_idle", {60'd0, cu.get_all_weights, cu.do_fp, cu.do_bp, cu.draw}, 64'd0);

    // Training run.
    clear_inputs();
    cu.start = 1'b1; cu.image_in = 32'hA5A5A5A5;
    cycle();
    cu.start = 1'b0; cu.weights_ack = 1'b1;
    cycle();
    cu.weights_ack = 1'b0; cu.fp_done = 1'b1; cu.train = 1'b1;
    cycle();
    check_eq("trn_bp", {62'd0, cu.do_bp, cu.draw}, 64'd2);
    cu.fp_done = 1'b0; cu.train = 1'b0; cu.bp_done = 1'b1;
    cycle();
    check_eq("trn_idle", {63'd0, cu.do_bp}, 64'd0);

    // Back-to-back: start held through DRAW->IDLE.
    clear_inputs();
    cu.start = 1'b1; cu.image_in = 32'h11110000;
    cycle();
    cu.weights_ack = 1'b1;
    cycle();
    cu.weights_ack = 1'b0; cu.fp_done = 1'b1;
    cycle();
    cu.fp_done = 1'b0; cu.drawn = 1'b1;
    cycle();
    check_eq("b2b_idle", {63'd0, cu.get_all_weights}, 64'd0);
    cu.drawn = 1'b0; cu.image_in = 32'h22220000;
    cycle();
    check_eq("b2b_weights", {63'd0, cu.get_all_weights}, 64'd1);
    check_eq("b2b_recapture", {32'd0, cu.image_out}, {32'd0, 32'h22220000});

    // Mid-run reset while in FP.
    cu.start = 1'b0; cu.weights_ack = 1'b1;
    cycle();
    cu.weights_ack = 1'b0;
    rst = 1'b0;
    cycle();
    check_eq("mid_rst_fp", {63'd0, cu.do_fp}, 64'd0);
    check_eq("mid_rst_image", {32'd0, cu.image_out}, 64'd0);
    rst = 1'b1;

    // Random stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 99) != 0);
      cu.start       = ($urandom_range(0, 9) < 3);
      cu.train       = $urandom_range(0, 1);
      cu.weights_ack = ($urandom_range(0, 9) < 4);
      cu.fp_done     = ($urandom_range(0, 9) < 4);
      cu.bp_done     = ($urandom_range(0, 9) < 4);
      cu.drawn       = ($urandom_range(0, 9) < 4);
      cu.image_in    = $urandom;
      cycle();
      check_eq("onehot0", {63'd0, $onehot0({cu.get_all_weights, cu.do_fp, cu.do_bp, cu.draw})},
               64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
